// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared defaults and next-pc select encoding for pc_seq
package pc_seq_pkg;
   localparam int PC_WIDTH_DEF = 16;
   localparam int INC_DEF = 1;
   localparam int RAS_DEPTH_DEF = 4;
   localparam logic [PC_WIDTH_DEF-1:0] RESET_VECTOR_DEF = '0;
   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BRANCH,
      SEL_JUMP,
      SEL_CALL,
      SEL_RET,
      SEL_HOLD
   } pc_sel_e;
   function automatic pc_sel_e pick_sel(input logic stall, ret, call, jump, branch, empty);
      return stall ? SEL_HOLD :
             (ret && !empty) ? SEL_RET :
             call ? SEL_CALL :
             ret ? SEL_SEQ :
             jump ? SEL_JUMP :
             branch ? SEL_BRANCH : SEL_SEQ;
   endfunction
endpackage

// File: rtl/pc_seq_ras_stack.sv
// ras_stack: circular return-address stack with saturating count and error pulses
module ras_stack #(
   parameter int W = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 push_data,
   output logic [W-1:0]                 top,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         ovf,
   output logic                         unf
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   logic [W-1:0] mem_q [DEPTH];
   logic [PW-1:0] sp_q, sp_d, top_idx, sp_inc, wr_idx;
   logic [CW-1:0] count_q, count_d;
   logic ovf_q, ovf_d, unf_q, unf_d;
   logic do_repl, do_push, do_pop, wr_en;
   always_comb begin
      empty   = count_q == '0;
      full    = count_q == CW'(DEPTH);
      top_idx = (sp_q == '0) ? PW'(DEPTH-1) : sp_q - PW'(1);
      sp_inc  = (sp_q == PW'(DEPTH-1)) ? '0 : sp_q + PW'(1);
      do_repl = push && pop && !empty;
      do_push = push && !do_repl;
      do_pop  = pop && !push && !empty;
      wr_en   = do_push || do_repl;
      wr_idx  = do_repl ? top_idx : sp_q;
      // sp_q is the next free slot; when full it also points at the oldest entry
      sp_d    = do_push ? sp_inc : do_pop ? top_idx : sp_q;
      count_d = (do_push && !full) ? count_q + CW'(1) : do_pop ? count_q - CW'(1) : count_q;
      ovf_d   = do_push && full;
      unf_d   = pop && empty;
      top     = mem_q[top_idx];
      count   = count_q;
      ovf     = ovf_q;
      unf     = unf_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         if (wr_en) mem_q[wr_idx] <= push_data;
      end
   end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: program counter sequencer with branch/jump/call/ret and return-address stack
module pc_seq import pc_seq_pkg::*; #(
   parameter int PC_WIDTH = PC_WIDTH_DEF,
   parameter int INC = INC_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
   parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                call,
   input  logic                ret,
   output logic [PC_WIDTH-1:0] pc,
   output logic                ras_empty,
   output logic                ras_full,
   output logic                ras_ovf,
   output logic                ras_unf
);
   localparam logic [PC_WIDTH-1:0] INC_W = PC_WIDTH'(INC);
   logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
   logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;
   pc_sel_e sel;
   ras_stack #(.W(PC_WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (call && !stall),
      .pop       (ret && !stall),
      .push_data (pc_inc),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty),
      .ovf       (ras_ovf),
      .unf       (ras_unf)
   );
   always_comb begin
      pc_inc = pc_q + INC_W;
      sel    = pick_sel(stall, ret, call, jump, branch_taken, ras_empty);
      pc_d   = (sel == SEL_HOLD) ? pc_q :
               (sel == SEL_RET) ? ras_top :
               (sel == SEL_CALL || sel == SEL_JUMP) ? jump_target :
               (sel == SEL_BRANCH) ? branch_target : pc_inc;
      pc     = pc_q;
   end
   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_VECTOR;
      else pc_q <= pc_d;
   end
   logic unused_count;
   assign unused_count = ^ras_count;
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed vectors with a queued scoreboard checked by an independent monitor
module tb_pc_seq;
   logic clk = 1'b0;
   logic rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
   logic [15:0] branch_target = '0, jump_target = '0;
   logic [15:0] pc;
   logic ras_empty, ras_full, ras_ovf, ras_unf;
   typedef struct {
      string nm;
      logic [15:0] pc;
      logic e, f, o, u;
   } exp_t;
   exp_t sb[$];
   int total = 0, bad = 0;
   bit done = 1'b0;

   pc_seq dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .call(call), .ret(ret),
      .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   task automatic cyc(input string nm, input logic r, s, c, rt, j, b,
                      input logic [15:0] jt, bt, epc, input logic ee, ef, eo, eu);
      exp_t x;
      rst = r; stall = s; call = c; ret = rt; jump = j; branch_taken = b;
      jump_target = jt; branch_target = bt;
      x.nm = nm; x.pc = epc; x.e = ee; x.f = ef; x.o = eo; x.u = eu;
      sb.push_back(x);
      @(posedge clk);
      #2;
   endtask

   initial begin
      exp_t x;
      while (!done) begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            total++;
            if ({pc, ras_empty, ras_full, ras_ovf, ras_unf} !== {x.pc, x.e, x.f, x.o, x.u}) begin
               bad++;
               $display("FAIL %s: got pc=%h e=%b f=%b ovf=%b unf=%b, want pc=%h e=%b f=%b ovf=%b unf=%b",
                        x.nm, pc, ras_empty, ras_full, ras_ovf, ras_unf, x.pc, x.e, x.f, x.o, x.u);
            end
         end
      end
   end

   initial begin
      //   name          r s c rt j b  jt       bt       pc      e f o u
      cyc("reset",       1,0,0,0,0,0, 16'h0000,16'h0000,16'h0000,1,0,0,0);
      cyc("seq1",        0,0,0,0,0,0, 16'h0000,16'h0000,16'h0001,1,0,0,0);
      cyc("seq2",        0,0,0,0,0,0, 16'h0000,16'h0000,16'h0002,1,0,0,0);
      cyc("seq3",        0,0,0,0,0,0, 16'h0000,16'h0000,16'h0003,1,0,0,0);
      cyc("seq4",        0,0,0,0,0,0, 16'h0000,16'h0000,16'h0004,1,0,0,0);
      cyc("jmp_fffe",    0,0,0,0,1,0, 16'hFFFE,16'h0000,16'hFFFE,1,0,0,0);
      cyc("wrap_ffff",   0,0,0,0,0,0, 16'h0000,16'h0000,16'hFFFF,1,0,0,0);
      cyc("wrap_0000",   0,0,0,0,0,0, 16'h0000,16'h0000,16'h0000,1,0,0,0);
      cyc("wrap_0001",   0,0,0,0,0,0, 16'h0000,16'h0000,16'h0001,1,0,0,0);
      cyc("jmp_0010",    0,0,0,0,1,0, 16'h0010,16'h0000,16'h0010,1,0,0,0);
      cyc("call_0100",   0,0,1,0,0,0, 16'h0100,16'h0000,16'h0100,0,0,0,0);
      cyc("ret_0011",    0,0,0,1,0,0, 16'h0000,16'h0000,16'h0011,1,0,0,0);
      cyc("jmp_0000",    0,0,0,0,1,0, 16'h0000,16'h0000,16'h0000,1,0,0,0);
      cyc("call1",       0,0,1,0,0,0, 16'h0001,16'h0000,16'h0001,0,0,0,0);
      cyc("call2",       0,0,1,0,0,0, 16'h0002,16'h0000,16'h0002,0,0,0,0);
      cyc("call3",       0,0,1,0,0,0, 16'h0003,16'h0000,16'h0003,0,0,0,0);
      cyc("call4_full",  0,0,1,0,0,0, 16'h0004,16'h0000,16'h0004,0,1,0,0);
      cyc("call5_ovf",   0,0,1,0,0,0, 16'h0005,16'h0000,16'h0005,0,1,1,0);
      cyc("ret_0005",    0,0,0,1,0,0, 16'h0000,16'h0000,16'h0005,0,0,0,0);
      cyc("ret_0004",    0,0,0,1,0,0, 16'h0000,16'h0000,16'h0004,0,0,0,0);
      cyc("ret_0003",    0,0,0,1,0,0, 16'h0000,16'h0000,16'h0003,0,0,0,0);
      cyc("ret_0002",    0,0,0,1,0,0, 16'h0000,16'h0000,16'h0002,1,0,0,0);
      cyc("ret_unf",     0,0,0,1,0,0, 16'h0000,16'h0000,16'h0003,1,0,0,1);
      cyc("unf_clear",   0,0,0,0,0,0, 16'h0000,16'h0000,16'h0004,1,0,0,0);
      cyc("jmp_0040",    0,0,0,0,1,0, 16'h0040,16'h0000,16'h0040,1,0,0,0);
      cyc("call_0080",   0,0,1,0,0,0, 16'h0080,16'h0000,16'h0080,0,0,0,0);
      cyc("callret_rep", 0,0,1,1,0,0, 16'h0090,16'h0000,16'h0041,0,0,0,0);
      cyc("ret_0081",    0,0,0,1,0,0, 16'h0000,16'h0000,16'h0081,1,0,0,0);
      cyc("callret_emp", 0,0,1,1,0,0, 16'h00A0,16'h0000,16'h00A0,0,0,0,1);
      cyc("ret_0082",    0,0,0,1,0,0, 16'h0000,16'h0000,16'h0082,1,0,0,0);
      cyc("jmp_0020",    0,0,0,0,1,0, 16'h0020,16'h0000,16'h0020,1,0,0,0);
      cyc("stall_jmp1",  0,1,0,0,1,0, 16'h0200,16'h0000,16'h0020,1,0,0,0);
      cyc("stall_jmp2",  0,1,0,0,1,0, 16'h0200,16'h0000,16'h0020,1,0,0,0);
      cyc("jmp_0200",    0,0,0,0,1,0, 16'h0200,16'h0000,16'h0200,1,0,0,0);
      cyc("call_0300",   0,0,1,0,0,0, 16'h0300,16'h0000,16'h0300,0,0,0,0);
      cyc("stall_ret",   0,1,0,1,0,0, 16'h0000,16'h0000,16'h0300,0,0,0,0);
      cyc("stall_call",  0,1,1,0,0,0, 16'h0400,16'h0000,16'h0300,0,0,0,0);
      cyc("ret_0201",    0,0,0,1,0,0, 16'h0000,16'h0000,16'h0201,1,0,0,0);
      cyc("branch_0555", 0,0,0,0,0,1, 16'h0000,16'h0555,16'h0555,1,0,0,0);
      cyc("jmp_over_br", 0,0,0,0,1,1, 16'h0600,16'h0700,16'h0600,1,0,0,0);
      cyc("call_over_j", 0,0,1,0,1,0, 16'h0610,16'h0000,16'h0610,0,0,0,0);
      cyc("ret_over_br", 0,0,0,1,0,1, 16'h0000,16'h0777,16'h0601,1,0,0,0);
      cyc("ret_emp_jmp", 0,0,0,1,1,0, 16'h0999,16'h0000,16'h0602,1,0,0,1);
      cyc("jmp_0030",    0,0,0,0,1,0, 16'h0030,16'h0000,16'h0030,1,0,0,0);
      cyc("fill1",       0,0,1,0,0,0, 16'h0031,16'h0000,16'h0031,0,0,0,0);
      cyc("fill2",       0,0,1,0,0,0, 16'h0032,16'h0000,16'h0032,0,0,0,0);
      cyc("fill3",       0,0,1,0,0,0, 16'h0033,16'h0000,16'h0033,0,0,0,0);
      cyc("fill4",       0,0,1,0,0,0, 16'h0034,16'h0000,16'h0034,0,1,0,0);
      cyc("rst_call",    1,0,1,0,0,0, 16'h0100,16'h0000,16'h0000,1,0,0,0);
      cyc("post_rst",    0,0,0,0,0,0, 16'h0000,16'h0000,16'h0001,1,0,0,0);
      cyc("post_rst_unf",0,0,0,1,0,0, 16'h0000,16'h0000,16'h0002,1,0,0,1);
      cyc("rst_stall",   1,1,0,0,0,0, 16'h0000,16'h0000,16'h0000,1,0,0,0);
      rst = 1'b0; stall = 1'b0; call = 1'b0; ret = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #3;
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d expected entries left, want 0", sb.size());
      end
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
